// File: rtl/tea_operand_loader.sv
// Byte-wide operand entry for the TEA core: synchronised and debounced go key,
// 192-bit shift register, and a valid/ready hand-off of v0, v1, k0..k3.
module tea_operand_loader #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_raw,
  input  logic [7:0]  data_in,
  input  logic        clear,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] v0,
  output logic [31:0] v1,
  output logic [31:0] k0,
  output logic [31:0] k1,
  output logic [31:0] k2,
  output logic [31:0] k3,
  output logic [4:0]  byte_index,
  output logic [2:0]  field_sel,
  output logic [7:0]  last_byte
);

  localparam logic [0:0] ENTRY   = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   go_sync;
  logic                   go_db;
  logic [CW-1:0]          db_cnt;
  logic                   db_toggle;
  logic                   accept;

  logic [0:0]   state;
  logic [191:0] sr;
  logic [4:0]   idx;
  logic [7:0]   last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], go_raw};
    end
  end

  assign go_sync = sync_q[SYNC_STAGES-1];

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  assign db_toggle = (go_sync != go_db) && (db_cnt == CNT_LAST);
  assign accept    = db_toggle && go_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_db  <= 1'b0;
      db_cnt <= '0;
    end else if (go_sync != go_db) begin
      if (db_cnt == CNT_LAST) begin
        go_db  <= ~go_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // clear outranks both a capture and a handshake; it never touches data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ENTRY;
      sr     <= '0;
      idx    <= '0;
      last_q <= '0;
    end else if (clear) begin
      state <= ENTRY;
      idx   <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (accept) begin
            sr     <= {sr[183:0], data_in};
            last_q <= data_in;
            idx    <= idx + 5'd1;
            if (idx == 5'd23) begin
              state <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state <= ENTRY;
            idx   <= '0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign out_valid  = (state == PRESENT);
  assign v0         = sr[191:160];
  assign v1         = sr[159:128];
  assign k0         = sr[127:96];
  assign k1         = sr[95:64];
  assign k2         = sr[63:32];
  assign k3         = sr[31:0];
  assign byte_index = idx;
  assign field_sel  = idx[4:2];
  assign last_byte  = last_q;

endmodule

// File: tb/tb_tea_operand_loader.sv
// Directed bench for tea_operand_loader with short synchroniser/debounce settings.
module tb_tea_operand_loader;

  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_raw;
  logic [7:0]  data_in;
  logic        clear;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] v0, v1, k0, k1, k2, k3;
  logic [4:0]  byte_index;
  logic [2:0]  field_sel;
  logic [7:0]  last_byte;

  int n_vec = 0;
  int n_err = 0;

  tea_operand_loader #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .go_raw(go_raw), .data_in(data_in),
    .clear(clear), .out_ready(out_ready), .out_valid(out_valid),
    .v0(v0), .v1(v1), .k0(k0), .k1(k1), .k2(k2), .k3(k3),
    .byte_index(byte_index), .field_sel(field_sel), .last_byte(last_byte)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Clean press: byte is captured SYNC+DB edges after go_raw rises, then released.
  task automatic press(input logic [7:0] b);
    @(posedge clk); #1;
    data_in = b;
    go_raw  = 1'b1;
    repeat (SYNC + DB) @(posedge clk);
    #1 go_raw = 1'b0;
    repeat (SYNC + DB + 1) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; go_raw = 1'b0; data_in = 8'h00; clear = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_index", {27'd0, byte_index}, 32'd0);
    chk("rst_v0", v0, 32'd0);
    chk("rst_last", {24'd0, last_byte}, 32'd0);
    reset = 1'b0;

    // Bounce rejection: 3-cycle pulses never survive a 4-cycle debounce.
    data_in = 8'h5A;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1 go_raw = ((i / 3) % 2 == 0);
    end
    chk("bounce_none", {27'd0, byte_index}, 32'd0);
    @(posedge clk); #1 go_raw = 1'b1;
    repeat (SYNC + DB - 1) @(posedge clk);
    #1 chk("bounce_early", {27'd0, byte_index}, 32'd0);
    @(posedge clk);
    #1 chk("bounce_cap", {27'd0, byte_index}, 32'd1);
    chk("bounce_last", {24'd0, last_byte}, 32'h5A);
    repeat (4) @(posedge clk);
    #1 go_raw = 1'b0;
    repeat (SYNC + DB + 1) @(posedge clk);
    chk("bounce_one", {27'd0, byte_index}, 32'd1);

    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    chk("clear_idx", {27'd0, byte_index}, 32'd0);

    // Full load 0x01..0x18; check the 24th capture edge explicitly.
    for (int b = 1; b <= 23; b++) press(8'(b));
    chk("load_idx23", {27'd0, byte_index}, 32'd23);
    chk("load_fsel5", {29'd0, field_sel}, 32'd5);
    @(posedge clk); #1 data_in = 8'h18; go_raw = 1'b1;
    repeat (SYNC + DB - 1) @(posedge clk);
    #1 chk("load_prevalid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 chk("load_valid", {31'd0, out_valid}, 32'd1);
    go_raw = 1'b0;
    chk("load_idx", {27'd0, byte_index}, 32'd24);
    chk("load_fsel", {29'd0, field_sel}, 32'd6);
    chk("load_v0", v0, 32'h01020304);
    chk("load_v1", v1, 32'h05060708);
    chk("load_k0", k0, 32'h090A0B0C);
    chk("load_k1", k1, 32'h0D0E0F10);
    chk("load_k2", k2, 32'h11121314);
    chk("load_k3", k3, 32'h15161718);
    repeat (SYNC + DB + 1) @(posedge clk);

    // Backpressure: presses while presenting are ignored.
    press(8'hEE);
    press(8'hEF);
    #1;
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_idx", {27'd0, byte_index}, 32'd24);
    chk("bp_v0", v0, 32'h01020304);
    chk("bp_k3", k3, 32'h15161718);
    chk("bp_last", {24'd0, last_byte}, 32'h18);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("hs_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_idx", {27'd0, byte_index}, 32'd0);

    // Clear collides with a capture at byte_index 7.
    for (int b = 1; b <= 7; b++) press(8'(b));
    @(posedge clk); #1 data_in = 8'hAA; go_raw = 1'b1;
    repeat (SYNC + DB - 1) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; go_raw = 1'b0;
    chk("coll_idx", {27'd0, byte_index}, 32'd0);
    chk("coll_last", {24'd0, last_byte}, 32'h07);
    chk("coll_k3", k3, 32'h04050607);
    repeat (SYNC + DB + 1) @(posedge clk);

    // Clear together with out_ready while presenting.
    for (int b = 8'h21; b <= 8'h38; b++) press(8'(b));
    #1 chk("p2_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1 clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 clear = 1'b0; out_ready = 1'b0;
    chk("clrp_valid", {31'd0, out_valid}, 32'd0);
    chk("clrp_idx", {27'd0, byte_index}, 32'd0);
    chk("clrp_v0", v0, 32'h21222324);
    press(8'h77);
    chk("clrp_entry", {27'd0, byte_index}, 32'd1);

    // Async reset mid-cycle while presenting.
    for (int b = 0; b < 23; b++) press(8'(8'h40 + b));
    #1 chk("p3_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_idx", {27'd0, byte_index}, 32'd0);
    chk("ar_v0", v0, 32'd0);
    chk("ar_v1", v1, 32'd0);
    chk("ar_kx", k0 | k1 | k2 | k3, 32'd0);
    #1 reset = 1'b0;
    press(8'h9C);
    chk("ar_cap_idx", {27'd0, byte_index}, 32'd1);
    chk("ar_cap_k3", k3, 32'h0000009C);
    chk("ar_cap_v0", v0, 32'd0);
    chk("ar_cap_last", {24'd0, last_byte}, 32'h9C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
